// File: rtl/cc_sched_pkg.sv
// rtl/cc_sched_pkg.sv - shared types, reset constant and CC encoder for cc_scheduler
package cc_sched_pkg;

    typedef enum logic {
        SETCC  = 1'b0,
        BRANCH = 1'b1
    } cc_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } cc_state_e;

    localparam logic [2:0] CC_RESET = 3'b010;

    // One-hot NZP for a 16-bit two's-complement result.
    function automatic logic [2:0] nzp_of(input logic [15:0] value);
        if (value == 16'h0000) begin
            return 3'b010;
        end else if (value[15]) begin
            return 3'b100;
        end else begin
            return 3'b001;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot request arbiter; round-robin, or fixed priority under CC_SCHED_FIXED_PRIO_EN
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

`ifdef CC_SCHED_FIXED_PRIO_EN

    logic unused_sigs;
    logic found;

    assign unused_sigs = Clk ^ Reset_n ^ advance;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

`else

    localparam int            PW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0]   NV   = (PW + 1)'(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx;
    logic [PW:0]   pos;
    logic          found;

    // Search starts at the pointer and wraps; first requester found wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_q} + (PW + 1)'(k);
            if (pos >= NV) begin
                pos = pos - NV;
            end
            if (!found && req[pos[PW-1:0]]) begin
                grant[pos[PW-1:0]] = 1'b1;
                gidx               = pos[PW-1:0];
                found              = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (gidx == LAST) ? '0 : gidx + PW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/cc_scheduler.sv
// rtl/cc_scheduler.sv - per-thread NZP file with one shared SETCC/BRANCH path (CC_SCHED_FIXED_PRIO_EN selects fixed priority)
module cc_scheduler
    import cc_sched_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [NUM_THREADS-1:0]   req_valid,
    output logic [NUM_THREADS-1:0]   req_ready,
    input  logic [NUM_THREADS-1:0]   req_op,
    input  logic [NUM_THREADS*16-1:0] req_data,
    input  logic [NUM_THREADS*3-1:0] req_nzp,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [TID_W-1:0]         resp_tid,
    output logic                     resp_op,
    output logic                     resp_taken,
    output logic [2:0]               resp_cc,
    output logic [NUM_THREADS*3-1:0] cc_out
);

    cc_state_e                state_q, state_d;
    logic [TID_W-1:0]         tid_q, tid_d;
    logic                     op_q, op_d;
    logic [15:0]              data_q, data_d;
    logic [2:0]               nzp_q, nzp_d;
    logic [NUM_THREADS*3-1:0] cc_q, cc_d;
    logic [TID_W-1:0]         resp_tid_q, resp_tid_d;
    logic                     resp_op_q, resp_op_d;
    logic                     resp_taken_q, resp_taken_d;
    logic [2:0]               resp_cc_q, resp_cc_d;

    logic [NUM_THREADS-1:0]   grant;
    logic                     accept;
    logic [2:0]               cc_cur;
    logic [2:0]               cc_new;

    assign accept = (state_q == IDLE) && (|req_valid);

    rr_arbiter #(
        .N (NUM_THREADS)
    ) u_arb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready  = (state_q == IDLE) ? grant : '0;
    assign resp_valid = (state_q == RESP);
    assign resp_tid   = resp_tid_q;
    assign resp_op    = resp_op_q;
    assign resp_taken = resp_taken_q;
    assign resp_cc    = resp_cc_q;
    assign cc_out     = cc_q;

    always_comb begin
        cc_cur = CC_RESET;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (tid_q == TID_W'(i)) begin
                cc_cur = cc_q[3*i +: 3];
            end
        end
        cc_new = nzp_of(data_q);
    end

    always_comb begin
        state_d      = state_q;
        tid_d        = tid_q;
        op_d         = op_q;
        data_d       = data_q;
        nzp_d        = nzp_q;
        cc_d         = cc_q;
        resp_tid_d   = resp_tid_q;
        resp_op_d    = resp_op_q;
        resp_taken_d = resp_taken_q;
        resp_cc_d    = resp_cc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int i = 0; i < NUM_THREADS; i++) begin
                        if (grant[i]) begin
                            tid_d  = TID_W'(i);
                            op_d   = req_op[i];
                            data_d = req_data[16*i +: 16];
                            nzp_d  = req_nzp[3*i +: 3];
                        end
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_tid_d = tid_q;
                resp_op_d  = op_q;
                if (cc_op_e'(op_q) == BRANCH) begin
                    resp_taken_d = |(cc_cur & nzp_q);
                    resp_cc_d    = cc_cur;
                end else begin
                    resp_taken_d = 1'b0;
                    resp_cc_d    = cc_new;
                    for (int i = 0; i < NUM_THREADS; i++) begin
                        if (tid_q == TID_W'(i)) begin
                            cc_d[3*i +: 3] = cc_new;
                        end
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also covers EXEC, so a pending CC write is simply lost.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            tid_q        <= '0;
            op_q         <= 1'b0;
            data_q       <= '0;
            nzp_q        <= '0;
            cc_q         <= {NUM_THREADS{CC_RESET}};
            resp_tid_q   <= '0;
            resp_op_q    <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_cc_q    <= CC_RESET;
        end else begin
            state_q      <= state_d;
            tid_q        <= tid_d;
            op_q         <= op_d;
            data_q       <= data_d;
            nzp_q        <= nzp_d;
            cc_q         <= cc_d;
            resp_tid_q   <= resp_tid_d;
            resp_op_q    <= resp_op_d;
            resp_taken_q <= resp_taken_d;
            resp_cc_q    <= resp_cc_d;
        end
    end

endmodule

// File: tb/tb_cc_scheduler.sv
// tb/tb_cc_scheduler.sv - directed self-checking bench for cc_scheduler
module tb_cc_scheduler;

    localparam int NT = 4;

`ifdef CC_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic [NT-1:0]    req_valid;
    logic [NT-1:0]    req_ready;
    logic [NT-1:0]    req_op;
    logic [NT*16-1:0] req_data;
    logic [NT*3-1:0]  req_nzp;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_tid;
    logic             resp_op;
    logic             resp_taken;
    logic [2:0]       resp_cc;
    logic [NT*3-1:0]  cc_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    cc_scheduler #(.NUM_THREADS(NT)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_nzp    (req_nzp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_tid   (resp_tid),
        .resp_op    (resp_op),
        .resp_taken (resp_taken),
        .resp_cc    (resp_cc),
        .cc_out     (cc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single isolated request with resp_ready high; starts and ends at a negedge in IDLE.
    task automatic do_req(input int tid, input logic op, input logic [15:0] data,
                          input logic [2:0] nzp, input logic exp_taken, input logic [2:0] exp_cc);
        req_valid = '0;
        req_valid[tid] = 1'b1;
        req_op[tid] = op;
        req_data[16*tid +: 16] = data;
        req_nzp[3*tid +: 3] = nzp;
        #1;
        check("accept_ready", 32'(req_ready), 32'(1) << tid);
        @(negedge Clk);
        req_valid = '0;
        check("exec_no_resp", 32'(resp_valid), 32'd0);
        @(negedge Clk);
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_tid", 32'(resp_tid), 32'(tid));
        check("resp_op", 32'(resp_op), 32'(op));
        check("resp_taken", 32'(exp_taken), 32'(resp_taken) ^ 32'd0);
        check("resp_cc", 32'(resp_cc), 32'(exp_cc));
        check("cc_out_slice", 32'(cc_out[3*tid +: 3]), 32'(exp_cc));
        @(negedge Clk);
    endtask

    initial begin
        int g1, g2;
        Reset_n    = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_data   = '0;
        req_nzp    = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_tid", 32'(resp_tid), 32'd0);
        check("rst_resp_op", 32'(resp_op), 32'd0);
        check("rst_resp_taken", 32'(resp_taken), 32'd0);
        check("rst_resp_cc", 32'(resp_cc), 32'h2);
        check("rst_cc_out", 32'(cc_out), 32'h492);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        do_req(2, 1'b1, 16'h0000, 3'b010, 1'b1, 3'b010);

        do_req(1, 1'b0, 16'h8000, 3'b000, 1'b0, 3'b100);
        do_req(1, 1'b1, 16'h0000, 3'b001, 1'b0, 3'b100);
        do_req(1, 1'b0, 16'h0005, 3'b000, 1'b0, 3'b001);
        check("cc_out_t1", 32'(cc_out[5:3]), 32'h1);

        do_req(3, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b010);
        do_req(3, 1'b1, 16'h0000, 3'b000, 1'b0, 3'b010);
        do_req(3, 1'b1, 16'h0000, 3'b111, 1'b1, 3'b010);
        do_req(3, 1'b0, 16'hFFFF, 3'b000, 1'b0, 3'b100);
        do_req(3, 1'b1, 16'h0000, 3'b000, 1'b0, 3'b100);
        do_req(3, 1'b1, 16'h0000, 3'b111, 1'b1, 3'b100);
        do_req(3, 1'b0, 16'h7FFF, 3'b000, 1'b0, 3'b001);
        do_req(3, 1'b1, 16'h0000, 3'b000, 1'b0, 3'b001);
        do_req(3, 1'b1, 16'h0000, 3'b111, 1'b1, 3'b001);

        // Pointer is 0 here (last grant was thread 3).
        req_op    = '1;
        req_nzp   = '0;
        req_valid = '1;
        for (int c = 0; c < 15; c++) begin
            int g;
            g = FIXED ? 0 : (c / 3) % NT;
            #1;
            check("rr_ready", 32'(req_ready), (c % 3 == 0) ? (32'(1) << g) : 32'd0);
            @(negedge Clk);
        end
        req_valid = '0;
        @(negedge Clk);

        // Pointer is 1 here; stall the response and watch it freeze.
        g1 = FIXED ? 0 : 2;
        g2 = FIXED ? 0 : 3;
        req_nzp    = '1;
        resp_ready = 1'b0;
        req_valid  = 4'b0101;
        #1;
        check("bp_accept", 32'(req_ready), 32'(1) << g1);
        @(negedge Clk);
        req_valid = 4'b1011;
        #1;
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        @(negedge Clk);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_tid", 32'(resp_tid), 32'(g1));
            check("bp_taken", 32'(resp_taken), 32'd1);
            check("bp_cc", 32'(resp_cc), 32'h2);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            @(negedge Clk);
        end
        resp_ready = 1'b1;
        check("bp_last_valid", 32'(resp_valid), 32'd1);
        @(negedge Clk);
        check("bp_done", 32'(resp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'(1) << g2);
        @(negedge Clk);
        req_valid = '0;
        @(negedge Clk);
        check("bp_next_tid", 32'(resp_tid), 32'(g2));
        @(negedge Clk);

        do_req(0, 1'b0, 16'h8000, 3'b000, 1'b0, 3'b100);
        req_valid = 4'b0001;
        req_op[0] = 1'b0;
        req_data[15:0] = 16'h0001;
        #1;
        check("rst_mid_accept", 32'(req_ready), 32'h1);
        @(negedge Clk);
        req_valid = '0;
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        check("rst_mid_cc", 32'(cc_out), 32'h492);
        check("rst_mid_resp_cc", 32'(resp_cc), 32'h2);
        @(negedge Clk);
        check("rst_mid_no_resp2", 32'(resp_valid), 32'd0);
        req_op    = '1;
        req_nzp   = '0;
        req_valid = '1;
        #1;
        check("rst_ptr_zero", 32'(req_ready), 32'h1);
        @(negedge Clk);
        req_valid = '0;
        @(negedge Clk);
        check("rst_ptr_tid", 32'(resp_tid), 32'd0);
        check("rst_ptr_taken", 32'(resp_taken), 32'd0);
        @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cc_scheduler.md
# cc_scheduler

Shared condition-code and branch-enable engine for the multi-thread SLC-3 core. It holds one NZP condition-code register per hardware thread and serves SETCC and BRANCH requests from all threads through one evaluation path, with round-robin arbitration. Responses are returned with valid/ready backpressure. It sits between the per-thread issue stages and the PC-update logic.

## Interface
- `NUM_THREADS`, default 4: number of requesting threads; must be at least 2.
- `TID_W`, default `$clog2(NUM_THREADS)`: thread-ID width.
- `Clk`  in  1: clock; all state updates on the rising edge.
- `Reset_n`  in  1: reset; synchronous and active-low.
- `req_valid`  in  NUM_THREADS: per-thread request valid.
- `req_ready`  out  NUM_THREADS: per-thread accept; one-hot or zero.
- `req_op`  in  NUM_THREADS: per-thread operation; 0 = SETCC, 1 = BRANCH.
- `req_data`  in  NUM_THREADS×16: per-thread result value (SETCC).
- `req_nzp`  in  NUM_THREADS×3: per-thread IR[11:9] branch mask (BRANCH).
- `resp_valid`  out  1: response valid.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_tid`  out  TID_W: thread served.
- `resp_op`  out  1: operation served.
- `resp_taken`  out  1: BRANCH only; (N&n)|(Z&z)|(P&p). Is 0 for SETCC.
- `resp_cc`  out  3: thread's NZP after the operation.
- `cc_out`  out  NUM_THREADS×3: live CC file; thread i is at [3i+2:3i], ordered N,Z,P.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, the arbiter picks one thread.
  - `req_ready[grant]` is asserted combinationally in the same cycle; the handshake completes.
  - tid, op, data and nzp are captured; next state is EXEC.
  - All `req_ready` bits are 0 in every other state.
- **EXEC, SETCC**: compute the new CC from the captured data and write it into the thread's CC entry at the end of EXEC.
  - data == 0 → 010.
  - data[15] = 1 → 100.
  - otherwise → 001.
- **EXEC, BRANCH**: compute taken from the thread's stored CC and the captured nzp. The CC file is not modified.
- After EXEC, registered response fields load and the FSM goes to RESP.
- **RESP**: `resp_valid` = 1 and all response fields stay stable until `resp_ready`. Next state is IDLE on the cycle `resp_ready` is sampled high.
- **Arbitration**: round-robin.
  - The pointer resets to 0.
  - After a grant, the pointer becomes grant+1, wrapping from NUM_THREADS-1 to 0.
  - The search starts at the pointer.
- Requesters hold `req_valid`, op, data and nzp stable until granted. Dropping `req_valid` before a grant is legal and simply withdraws the request.
- Requests are fully serialized, so a BRANCH granted after a SETCC from the same thread sees the updated CC.
- Every possible CC value is one-hot.
  - nzp = 000 → never taken.
  - nzp = 111 → always taken.
- **Reset values**:
  - state IDLE; RR pointer 0.
  - every CC entry 010 (Z).
  - `resp_valid` 0; `resp_tid`, `resp_op`, `resp_taken` 0; `resp_cc` 010; `req_ready` all 0.
- **Reset mid-operation**: an in-flight request is dropped with no response. The CC write is suppressed if reset occurs in EXEC.

## Timing
- Accept in cycle t (IDLE) → EXEC in t+1 → `resp_valid` from t+2.
- With `resp_ready` held high, the next accept can occur at t+3.
- Peak throughput is one request per 3 cycles.
- A SETCC's CC change is visible on `cc_out` from cycle t+2.
- `req_ready` depends combinationally on `req_valid` and the state only, never on `resp_ready`.
- Backpressure: while RESP is stalled, no new request is accepted and the RR pointer is frozen.

## Configuration
- `CC_SCHED_FIXED_PRIO_EN` defined: fixed priority. The lowest-indexed valid thread always wins and the RR pointer is removed.
- Undefined (default): round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Structure
- Package `cc_sched_pkg` holds:
  - `cc_op_e` enum: SETCC = 0, BRANCH = 1.
  - `cc_state_e` enum: IDLE, EXEC, RESP.
  - constant `CC_RESET = 3'b010`.
  - function `nzp_of(logic [15:0])` returning the one-hot CC.
- Sub-module `rr_arbiter`, parameterized by N:
  - inputs: request vector, advance strobe.
  - output: one-hot grant.
  - owns the pointer.
  - implements fixed priority under the macro.
- `cc_scheduler` holds the FSM, capture registers and CC file.

## Test plan
- Reset, then thread 2 BRANCH with nzp = 010 → `resp_tid` = 2, `resp_taken` = 1, `resp_cc` = 010, `resp_valid` at accept+2.
- Thread 1 SETCC with data 16'h8000, then thread 1 BRANCH with nzp = 001 → first response `resp_cc` = 100; branch `resp_taken` = 0. Then SETCC with 16'h0005 → `cc_out`[5:3] = 001.
- All four threads request continuously with `resp_ready` = 1 → grant order 0,1,2,3,0, one accept every 3 cycles. Under `CC_SCHED_FIXED_PRIO_EN`, thread 0 is granted every time.
- Hold `resp_ready` = 0 for 5 cycles in RESP → response fields stable, `req_ready` stays 0, pointer frozen; completion occurs the cycle `resp_ready` rises.
- Assert `Reset_n` = 0 during EXEC of a SETCC with 16'h0001 → no response; that thread's CC is 010 afterwards.
- BRANCH with nzp = 000 and with nzp = 111 for each CC value → taken is always 0 and always 1 respectively.
